// File: rtl/brick_field_if.sv
// Brick-field bus: groups the level-load, collision-check and plot handshakes
// between the game FSM / VGA drawer (master side) and brick_field (slave side).
//   load_level, level_map        level load request and per-brick hit counts
//   check, ball_*                collision check request and ball state
//   check_done, hit_valid,
//   bounce_x, bounce_y           collision result pulse
//   plot_start, plot_*, plot_done  rectangle draw handshake
//   busy, bricks_left, score,
//   field_clear                  status
interface brick_field_if #(
   parameter int ROWS    = 3,
   parameter int COLS    = 10,
   parameter int HIT_W   = 2,
   parameter int SCORE_W = 11
);
   localparam int BL_W = $clog2(ROWS * COLS + 1);

   logic                        load_level;
   logic [ROWS*COLS*HIT_W-1:0]  level_map;
   logic                        check;
   logic [7:0]                  ball_x;
   logic [6:0]                  ball_y;
   logic                        ball_right;
   logic                        ball_down;
   logic                        plot_done;

   logic                        plot_start;
   logic [7:0]                  plot_x;
   logic [6:0]                  plot_y;
   logic [7:0]                  plot_w;
   logic [6:0]                  plot_h;
   logic [2:0]                  plot_obj;
   logic                        check_done;
   logic                        hit_valid;
   logic                        bounce_x;
   logic                        bounce_y;
   logic                        busy;
   logic [BL_W-1:0]             bricks_left;
   logic [SCORE_W-1:0]          score;
   logic                        field_clear;

   modport master (
      output load_level, level_map, check, ball_x, ball_y, ball_right, ball_down, plot_done,
      input  plot_start, plot_x, plot_y, plot_w, plot_h, plot_obj, check_done, hit_valid,
             bounce_x, bounce_y, busy, bricks_left, score, field_clear
   );

   modport slave (
      input  load_level, level_map, check, ball_x, ball_y, ball_right, ball_down, plot_done,
      output plot_start, plot_x, plot_y, plot_w, plot_h, plot_obj, check_done, hit_valid,
             bounce_x, bounce_y, busy, bricks_left, score, field_clear
   );
endinterface

// File: rtl/brick_field.sv
// Brick-field engine: holds a ROWS x COLS array of multi-hit bricks, redraws
// the whole field after a level load, answers collision checks with bounce
// directions, decrements the hit brick and redraws it.
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     brick_field_if slave modport (load, check, plot handshake, status)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for load_level (priority) or check
// SWEEP_REQ  | plot_start high for brick sweepIdx
// SWEEP_WAIT | waiting plot_done for brick sweepIdx, then count it
// CHECK      | probes evaluated on registered ball state, result registered
// UPDATE     | result pulse visible; start redraw on hit, else return
// DRAW_REQ   | plot_start high for the hit brick
// DRAW_WAIT  | waiting plot_done for the hit brick
module brick_field #(
   parameter int COLS      = 10,
   parameter int ROWS      = 3,
   parameter int BOX_W     = 16,
   parameter int BOX_H     = 8,
   parameter int HIT_W     = 2,
   parameter int BALL_SIZE = 4,
   parameter int SCORE_W   = 11
) (
   input logic          clk,
   input logic          resetn,
   brick_field_if.slave bus
);
   localparam int N       = ROWS * COLS;
   localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
   localparam int BL_W    = $clog2(N + 1);
   localparam int FIELD_W = COLS * BOX_W;
   localparam int FIELD_H = ROWS * BOX_H;

   localparam logic [2:0] OBJ_BRICK = 3'b010;
   localparam logic [2:0] OBJ_ERASE = 3'b011;

   typedef enum logic [2:0] {
      IDLE, SWEEP_REQ, SWEEP_WAIT, CHECK, UPDATE, DRAW_REQ, DRAW_WAIT
   } stateT;

   stateT              state;
   logic [HIT_W-1:0]   brick [N];
   logic [IDX_W-1:0]   sweepIdx;
   logic [7:0]         ballXq;
   logic [6:0]         ballYq;
   logic               rightQ;
   logic               downQ;
   logic               loaded;

   logic               plotStart;
   logic [7:0]         plotX;
   logic [6:0]         plotY;
   logic [7:0]         plotW;
   logic [6:0]         plotH;
   logic [2:0]         plotObj;
   logic               checkDone;
   logic               hitValid;
   logic               bounceX;
   logic               bounceY;
   logic               busy;
   logic [BL_W-1:0]    bricksLeft;
   logic [SCORE_W-1:0] score;
   logic               fieldClear;

   function automatic logic [7:0] colX(input logic [IDX_W-1:0] idx);
      return 8'((int'(idx) % COLS) * BOX_W);
   endfunction

   function automatic logic [6:0] rowY(input logic [IDX_W-1:0] idx);
      return 7'((int'(idx) / COLS) * BOX_H);
   endfunction

   function automatic logic [IDX_W-1:0] pixIdx(input logic [9:0] x, input logic [9:0] y);
      return IDX_W'((int'(y) / BOX_H) * COLS + int'(x) / BOX_W);
   endfunction

   // Probe geometry. Coordinates are widened to 10 bits so that a leading
   // edge past the right/bottom border or below zero lands outside the field
   // instead of wrapping back into it.
   logic [9:0]       leadX, leadY, midX, midY;
   logic             leadXOk, leadYOk, midXOk, midYOk;
   logic [IDX_W-1:0] hIdx, vIdx, cIdx;
   logic             hHit, vHit, cHit;
   logic             hitAny, hitBx, hitBy;
   logic [IDX_W-1:0] hitIdx;
   logic [HIT_W-1:0] cntNext;
   logic [BL_W-1:0]  blAfterHit;
   logic             sweepNz;
   logic [BL_W-1:0]  blAfterSweep;
   logic [IDX_W-1:0] nextIdx;

   always_comb begin
      leadX   = rightQ ? 10'(ballXq) + 10'(BALL_SIZE) : 10'(ballXq) - 10'd1;
      leadY   = downQ  ? 10'(ballYq) + 10'(BALL_SIZE) : 10'(ballYq) - 10'd1;
      midX    = 10'(ballXq) + 10'(BALL_SIZE / 2);
      midY    = 10'(ballYq) + 10'(BALL_SIZE / 2);
      leadXOk = (rightQ || (ballXq != '0)) && (leadX < 10'(FIELD_W));
      leadYOk = (downQ  || (ballYq != '0)) && (leadY < 10'(FIELD_H));
      midXOk  = midX < 10'(FIELD_W);
      midYOk  = midY < 10'(FIELD_H);

      // Indices are forced to 0 for invalid probes so the array read stays in range.
      hIdx = (leadXOk && midYOk)  ? pixIdx(leadX, midY)  : '0;
      vIdx = (midXOk  && leadYOk) ? pixIdx(midX,  leadY) : '0;
      cIdx = (leadXOk && leadYOk) ? pixIdx(leadX, leadY) : '0;
      hHit = leadXOk && midYOk  && (brick[hIdx] != '0);
      vHit = midXOk  && leadYOk && (brick[vIdx] != '0);
      cHit = leadXOk && leadYOk && (brick[cIdx] != '0);

      hitAny = 1'b0;
      hitIdx = '0;
      hitBx  = 1'b0;
      hitBy  = 1'b0;
      if (hHit) begin
         hitAny = 1'b1;
         hitIdx = hIdx;
         hitBx  = 1'b1;
      end else if (vHit) begin
         hitAny = 1'b1;
         hitIdx = vIdx;
         hitBy  = 1'b1;
      end else if (cHit) begin
         hitAny = 1'b1;
         hitIdx = cIdx;
         hitBx  = 1'b1;
         hitBy  = 1'b1;
      end

      cntNext      = brick[hitIdx] - HIT_W'(1);
      blAfterHit   = (cntNext == '0) ? bricksLeft - BL_W'(1) : bricksLeft;
      sweepNz      = brick[sweepIdx] != '0;
      blAfterSweep = sweepNz ? bricksLeft + BL_W'(1) : bricksLeft;
      nextIdx      = sweepIdx + IDX_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         for (int i = 0; i < N; i++) brick[i] <= '0;
         sweepIdx   <= '0;
         ballXq     <= '0;
         ballYq     <= '0;
         rightQ     <= 1'b0;
         downQ      <= 1'b0;
         loaded     <= 1'b0;
         plotStart  <= 1'b0;
         plotX      <= '0;
         plotY      <= '0;
         plotW      <= '0;
         plotH      <= '0;
         plotObj    <= OBJ_ERASE;
         checkDone  <= 1'b0;
         hitValid   <= 1'b0;
         bounceX    <= 1'b0;
         bounceY    <= 1'b0;
         busy       <= 1'b0;
         bricksLeft <= '0;
         score      <= '0;
         fieldClear <= 1'b0;
      end else begin
         plotStart <= 1'b0;
         checkDone <= 1'b0;
         hitValid  <= 1'b0;
         bounceX   <= 1'b0;
         bounceY   <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.load_level) begin
                  for (int i = 0; i < N; i++) brick[i] <= bus.level_map[i*HIT_W +: HIT_W];
                  bricksLeft <= '0;
                  loaded     <= 1'b0;
                  fieldClear <= 1'b0;
                  sweepIdx   <= '0;
                  busy       <= 1'b1;
                  // First sweep request is issued straight from the load
                  // edge, so its object comes from the incoming map.
                  plotStart  <= 1'b1;
                  plotX      <= '0;
                  plotY      <= '0;
                  plotW      <= 8'(BOX_W);
                  plotH      <= 7'(BOX_H);
                  plotObj    <= (bus.level_map[HIT_W-1:0] != '0) ? OBJ_BRICK : OBJ_ERASE;
                  state      <= SWEEP_REQ;
               end else if (bus.check) begin
                  ballXq <= bus.ball_x;
                  ballYq <= bus.ball_y;
                  rightQ <= bus.ball_right;
                  downQ  <= bus.ball_down;
                  busy   <= 1'b1;
                  state  <= CHECK;
               end
            end

            SWEEP_REQ: state <= SWEEP_WAIT;

            SWEEP_WAIT: begin
               if (bus.plot_done) begin
                  bricksLeft <= blAfterSweep;
                  if (sweepIdx == IDX_W'(N - 1)) begin
                     loaded     <= 1'b1;
                     fieldClear <= (blAfterSweep == '0);
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     sweepIdx  <= nextIdx;
                     plotStart <= 1'b1;
                     plotX     <= colX(nextIdx);
                     plotY     <= rowY(nextIdx);
                     plotObj   <= (brick[nextIdx] != '0) ? OBJ_BRICK : OBJ_ERASE;
                     state     <= SWEEP_REQ;
                  end
               end
            end

            CHECK: begin
               checkDone <= 1'b1;
               if (hitAny) begin
                  hitValid      <= 1'b1;
                  bounceX       <= hitBx;
                  bounceY       <= hitBy;
                  brick[hitIdx] <= cntNext;
                  score         <= (score == '1) ? score : score + SCORE_W'(1);
                  bricksLeft    <= blAfterHit;
                  fieldClear    <= loaded && (blAfterHit == '0);
                  plotX         <= colX(hitIdx);
                  plotY         <= rowY(hitIdx);
                  plotW         <= 8'(BOX_W);
                  plotH         <= 7'(BOX_H);
                  plotObj       <= (cntNext != '0) ? OBJ_BRICK : OBJ_ERASE;
               end
               state <= UPDATE;
            end

            UPDATE: begin
               // hitValid is still high here for exactly the cycle after CHECK.
               if (hitValid) begin
                  plotStart <= 1'b1;
                  state     <= DRAW_REQ;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            DRAW_REQ: state <= DRAW_WAIT;

            DRAW_WAIT: begin
               if (bus.plot_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.plot_start  = plotStart;
   assign bus.plot_x      = plotX;
   assign bus.plot_y      = plotY;
   assign bus.plot_w      = plotW;
   assign bus.plot_h      = plotH;
   assign bus.plot_obj    = plotObj;
   assign bus.check_done  = checkDone;
   assign bus.hit_valid   = hitValid;
   assign bus.bounce_x    = bounceX;
   assign bus.bounce_y    = bounceY;
   assign bus.busy        = busy;
   assign bus.bricks_left = bricksLeft;
   assign bus.score       = score;
   assign bus.field_clear = fieldClear;
endmodule
